pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken branches, jumps, data-memory wait states and interrupt entry.
- Drives the write-enable, flush, bubble and hold controls of the pipeline registers and the PC.
- Sits beside the control decoder in ID; all outputs are consumed in the same cycle by the pipeline registers and the PC mux.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
STALL_CNT_W, 32, width of stall counter (optional feature)

Ports:
sysclk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UsesRt  in  1  instruction in ID reads rt
ID_Branch  in  1  conditional branch decoded in ID
ID_Jump  in  1  J/JAL/JR/JALR decoded in ID
EX_MemRead  in  1  load in EX
EX_Rt  in  5  destination of load in EX
EX_BranchTaken  in  1  branch resolved taken in EX
MEM_Ready  in  1  data memory access complete (low = wait)
IRQ_Req  in  1  interrupt request, level
IRQ_Clear  in  1  one-cycle pulse from exception-return; unmasks IRQ
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID load enable
IF_Flush  out  1  zero IF/ID instruction
ID_EX_Bubble  out  1  zero ID/EX control fields
ID_EX_Hold  out  1  ID/EX keeps contents
EX_MEM_Hold  out  1  EX/MEM keeps contents
ID_IRQ  out  1  tag instruction in ID as interrupt entry
Stall_Count  out  STALL_CNT_W  cycles with PC_Write=0

Behaviour:
- State register: RUN, LSTALL, MWAIT. Flags: irq_pend, irq_mask. Counter: lcnt, 3 bits.
- reset=1 at an edge sets state=RUN, lcnt=0, irq_pend=0, irq_mask=0, Stall_Count=0.
- Outputs while reset=1: PC_Write=0, IF_ID_Write=0, IF_Flush=1, ID_EX_Bubble=1, ID_EX_Hold=0, EX_MEM_Hold=0, ID_IRQ=0.
- Outputs are combinational from current state and inputs (zero latency). State updates on the next edge.
- Default (RUN, no event): PC_Write=1, IF_ID_Write=1, all other outputs 0.
- Priority, highest first:
  - (1) MEM_Ready=0:
    - PC_Write=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Hold=1; flush, bubble and ID_IRQ forced 0.
    - Next state MWAIT; remain in MWAIT while MEM_Ready=0.
    - lcnt frozen. Held EX inputs are re-evaluated in the cycle MEM_Ready returns to 1, so a deferred taken branch or load-use acts then.
  - (2) EX_BranchTaken=1: IF_Flush=1, ID_EX_Bubble=1, PC_Write=1. Cancels any load-use stall (lcnt cleared, state RUN).
  - (3) Load-use hazard: EX_MemRead & EX_Rt!=0 & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)).
    - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
    - If LOAD_STALL_CYCLES>1: next state LSTALL, lcnt=LOAD_STALL_CYCLES-1.
    - LSTALL repeats the stall outputs, decrements lcnt, and returns to RUN when lcnt reaches 1.
    - ID_Jump in the same cycle does not flush; the stall wins.
  - (4) ID_Jump=1: IF_Flush=1, PC_Write=1.
  - (5) IRQ injection: irq_pend & ~irq_mask & ~ID_Branch & ~ID_Jump & state RUN.
    - ID_IRQ=1 and IF_Flush=1 for exactly one cycle; then irq_mask=1 and irq_pend=0.
- irq_pend is set on any cycle with IRQ_Req=1 & ~irq_mask; it is held until injection.
- IRQ_Clear=1 clears irq_mask on the next edge. If IRQ_Clear coincides with injection, the mask stays set.
- MWAIT exit: the first cycle with MEM_Ready=1 evaluates priorities 2-5 normally; state returns to RUN, or to LSTALL if lcnt>0.
- Reset asserted mid-LSTALL or mid-MWAIT aborts immediately; no pending stall or IRQ survives.

Optional Feature:
STALL_COUNTER_EN
- Defined: Stall_Count increments each cycle PC_Write=0 and reset=0. It saturates at all-ones and clears only on reset.
- Undefined: Stall_Count tied to 0 and no counter logic is present.

Test Plan:
- Load-use: lw $8 in EX (EX_MemRead=1, EX_Rt=8), ID_Rs=8 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, then default; with LOAD_STALL_CYCLES=3 -> exactly 3 stall cycles.
- EX_Rt=0 with ID_Rs=0, EX_MemRead=1 -> no stall; ID_UsesRt=0, EX_Rt=ID_Rt=5 -> no stall.
- EX_BranchTaken=1 together with a load-use hazard -> IF_Flush=1, ID_EX_Bubble=1, PC_Write=1; LSTALL aborted.
- MEM_Ready low 4 cycles while EX_BranchTaken=1 -> 4 cycles all holds=1, IF_Flush=0; flush asserted in the cycle MEM_Ready=1; Stall_Count=4 with STALL_COUNTER_EN.
- IRQ_Req pulses while ID_Jump=1 -> no injection; next RUN cycle ID_IRQ=1 and IF_Flush=1 for one cycle; a second IRQ_Req is ignored until IRQ_Clear is pulsed.
- reset=1 during MWAIT with MEM_Ready=0 -> reset output values next cycle; after release, state RUN and default outputs.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch/jump, memory-wait and interrupt-entry control.
// Optional STALL_COUNTER_EN macro enables the saturating Stall_Count counter.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 32
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [4:0]             ID_Rs,
  input  logic [4:0]             ID_Rt,
  input  logic                   ID_UsesRt,
  input  logic                   ID_Branch,
  input  logic                   ID_Jump,
  input  logic                   EX_MemRead,
  input  logic [4:0]             EX_Rt,
  input  logic                   EX_BranchTaken,
  input  logic                   MEM_Ready,
  input  logic                   IRQ_Req,
  input  logic                   IRQ_Clear,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_Flush,
  output logic                   ID_EX_Bubble,
  output logic                   ID_EX_Hold,
  output logic                   EX_MEM_Hold,
  output logic                   ID_IRQ,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_MWAIT  = 2'd2;
  localparam logic [2:0] LCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic       irq_pend_q, irq_pend_d;
  logic       irq_mask_q, irq_mask_d;
  logic       load_use;
  logic       in_lstall;
  logic       inject;

  assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  // Leaving MWAIT with a frozen non-zero count resumes the interrupted load stall.
  assign in_lstall = (state_q == ST_LSTALL) || ((state_q == ST_MWAIT) && (lcnt_q != 3'd0));

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_Flush     = 1'b0;
    ID_EX_Bubble = 1'b0;
    ID_EX_Hold   = 1'b0;
    EX_MEM_Hold  = 1'b0;
    ID_IRQ       = 1'b0;
    state_d      = state_q;
    lcnt_d       = lcnt_q;
    inject       = 1'b0;

    if (!MEM_Ready) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Hold  = 1'b1;
      EX_MEM_Hold = 1'b1;
      state_d     = ST_MWAIT;
    end else if (EX_BranchTaken) begin
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_d      = ST_RUN;
      lcnt_d       = 3'd0;
    end else if (in_lstall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      if (lcnt_q <= 3'd1) begin
        state_d = ST_RUN;
        lcnt_d  = 3'd0;
      end else begin
        state_d = ST_LSTALL;
        lcnt_d  = lcnt_q - 3'd1;
      end
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = ST_LSTALL;
        lcnt_d  = LCNT_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end else if (ID_Jump) begin
      IF_Flush = 1'b1;
      state_d  = ST_RUN;
    end else begin
      state_d = ST_RUN;
      inject  = irq_pend_q && !irq_mask_q && !ID_Branch;
      if (inject) begin
        ID_IRQ   = 1'b1;
        IF_Flush = 1'b1;
      end
    end

    irq_pend_d = irq_pend_q;
    if (inject) begin
      irq_pend_d = 1'b0;
    end else if (IRQ_Req && !irq_mask_q) begin
      irq_pend_d = 1'b1;
    end

    // Injection wins over a coincident exception-return so the new handler stays masked.
    irq_mask_d = irq_mask_q;
    if (inject) begin
      irq_mask_d = 1'b1;
    end else if (IRQ_Clear) begin
      irq_mask_d = 1'b0;
    end

    if (reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      ID_EX_Hold   = 1'b0;
      EX_MEM_Hold  = 1'b0;
      ID_IRQ       = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      lcnt_q     <= 3'd0;
      irq_pend_q <= 1'b0;
      irq_mask_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      irq_pend_q <= irq_pend_d;
      irq_mask_q <= irq_mask_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
`else
  assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default instance plus a LOAD_STALL_CYCLES=3 instance.
module tb_pipeline_hazard_ctrl;

  logic        sysclk;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_Branch, ID_Jump, EX_MemRead, EX_BranchTaken;
  logic        MEM_Ready, IRQ_Req, IRQ_Clear;
  logic        PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold, ID_IRQ;
  logic [31:0] Stall_Count;
  logic        PC_Write3, IF_ID_Write3, IF_Flush3, ID_EX_Bubble3, ID_EX_Hold3, EX_MEM_Hold3, ID_IRQ3;
  logic [31:0] Stall_Count3;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;

  // Output vector order: PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold, ID_IRQ
  localparam logic [6:0] V_RST = 7'b0011000;
  localparam logic [6:0] V_DEF = 7'b1100000;
  localparam logic [6:0] V_LU  = 7'b0001000;
  localparam logic [6:0] V_MW  = 7'b0000110;
  localparam logic [6:0] V_BR  = 7'b1111000;
  localparam logic [6:0] V_JMP = 7'b1110000;
  localparam logic [6:0] V_IRQ = 7'b1110001;

  pipeline_hazard_ctrl dut (
    .sysclk(sysclk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Ready(MEM_Ready), .IRQ_Req(IRQ_Req),
    .IRQ_Clear(IRQ_Clear), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush), .ID_EX_Bubble(ID_EX_Bubble), .ID_EX_Hold(ID_EX_Hold),
    .EX_MEM_Hold(EX_MEM_Hold), .ID_IRQ(ID_IRQ), .Stall_Count(Stall_Count)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
    .sysclk(sysclk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Ready(MEM_Ready), .IRQ_Req(IRQ_Req),
    .IRQ_Clear(IRQ_Clear), .PC_Write(PC_Write3), .IF_ID_Write(IF_ID_Write3),
    .IF_Flush(IF_Flush3), .ID_EX_Bubble(ID_EX_Bubble3), .ID_EX_Hold(ID_EX_Hold3),
    .EX_MEM_Hold(EX_MEM_Hold3), .ID_IRQ(ID_IRQ3), .Stall_Count(Stall_Count3)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic clr();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
    ID_UsesRt = 1'b0; ID_Branch = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Ready = 1'b1; IRQ_Req = 1'b0; IRQ_Clear = 1'b0;
  endtask

  // Inputs are applied at the falling edge; outputs are checked 1ns later, then the bench
  // waits for the next falling edge so the rising edge in between commits state.
  task automatic cyc(input logic [6:0] e, input string tag, input bit do3 = 1'b0,
                     input logic [6:0] e3 = 7'b0);
    logic [6:0] obs;
    logic [6:0] obs3;
    #1;
    obs  = {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold, ID_IRQ};
    obs3 = {PC_Write3, IF_ID_Write3, IF_Flush3, ID_EX_Bubble3, ID_EX_Hold3, EX_MEM_Hold3, ID_IRQ3};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, obs, e);
    end
    checks++;
    assert (Stall_Count === exp_cnt) else begin
      errors++;
      $error("FAIL %s Stall_Count obs=%0d exp=%0d", tag, Stall_Count, exp_cnt);
    end
    if (do3) begin
      checks++;
      assert (obs3 === e3) else begin
        errors++;
        $error("FAIL %s dut3 outputs obs=%b exp=%b", tag, obs3, e3);
      end
    end
    $display("step %-14s reset=%b obs=%b exp=%b cnt=%0d", tag, reset, obs, e, Stall_Count);
`ifdef STALL_COUNTER_EN
    if (reset) exp_cnt = '0;
    else if (!e[6]) exp_cnt = exp_cnt + 1;
`endif
    @(negedge sysclk);
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(negedge sysclk);
    cyc(V_RST, "reset0", 1'b1, V_RST);
    cyc(V_RST, "reset1", 1'b1, V_RST);
    reset = 1'b0;
    cyc(V_DEF, "default", 1'b1, V_DEF);

    // Load-use on rs: one stall cycle, three on the LOAD_STALL_CYCLES=3 instance
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    cyc(V_LU, "lu_rs", 1'b1, V_LU);
    clr();
    cyc(V_DEF, "lu_after1", 1'b1, V_LU);
    cyc(V_DEF, "lu_after2", 1'b1, V_LU);
    cyc(V_DEF, "lu_after3", 1'b1, V_DEF);

    // Taken branch aborts a multi-cycle load stall
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    cyc(V_LU, "abort_lu", 1'b1, V_LU);
    clr(); EX_BranchTaken = 1'b1;
    cyc(V_BR, "abort_br", 1'b1, V_BR);
    clr();
    cyc(V_DEF, "abort_after", 1'b1, V_DEF);

    // Branch taken together with a load-use hazard
    EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    cyc(V_BR, "br_with_lu");
    clr();

    // Hazard boundaries
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    cyc(V_DEF, "rt_zero");
    EX_Rt = 5'd5; ID_Rt = 5'd5; ID_Rs = 5'd1; ID_UsesRt = 1'b0;
    cyc(V_DEF, "rt_unused");
    ID_UsesRt = 1'b1;
    cyc(V_LU, "lu_rt");
    clr();
    cyc(V_DEF, "lu_rt_after");
    EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rs = 5'd9; ID_Jump = 1'b1;
    cyc(V_LU, "lu_beats_jump");
    clr(); ID_Jump = 1'b1;
    cyc(V_JMP, "jump");
    clr();

    // Memory wait holding a taken branch, branch acts when memory is ready
    EX_BranchTaken = 1'b1; MEM_Ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(V_MW, "mwait_br");
    MEM_Ready = 1'b1;
    cyc(V_BR, "mwait_exit_br");
    clr();
    cyc(V_DEF, "mwait_done");

    // Memory wait holding a load-use hazard
    EX_MemRead = 1'b1; EX_Rt = 5'd3; ID_Rs = 5'd3; MEM_Ready = 1'b0;
    cyc(V_MW, "mwait_lu");
    MEM_Ready = 1'b1;
    cyc(V_LU, "mwait_exit_lu");
    clr();
    cyc(V_DEF, "mwait_lu_done");

    // Interrupt deferred by a jump, then injected once; masked until IRQ_Clear
    IRQ_Req = 1'b1; ID_Jump = 1'b1;
    cyc(V_JMP, "irq_jump");
    clr();
    cyc(V_IRQ, "irq_inject");
    cyc(V_DEF, "irq_once");
    IRQ_Req = 1'b1;
    cyc(V_DEF, "irq_masked");
    clr();
    cyc(V_DEF, "irq_masked2");
    IRQ_Clear = 1'b1;
    cyc(V_DEF, "irq_clear");
    clr();
    cyc(V_DEF, "irq_idle");

    // Interrupt blocked while a branch is in ID
    IRQ_Req = 1'b1; ID_Branch = 1'b1;
    cyc(V_DEF, "irq_req_br");
    IRQ_Req = 1'b0;
    cyc(V_DEF, "irq_block_br");
    ID_Branch = 1'b0; IRQ_Clear = 1'b1;
    cyc(V_IRQ, "irq_inj_clr");
    clr(); IRQ_Req = 1'b1;
    cyc(V_DEF, "irq_mask_kept");
    clr();
    cyc(V_DEF, "irq_no_inject");

    // Reset during memory wait
    MEM_Ready = 1'b0;
    cyc(V_MW, "mw_pre_reset");
    reset = 1'b1;
    cyc(V_RST, "reset_in_mw");
    reset = 1'b0; MEM_Ready = 1'b1;
    cyc(V_DEF, "post_reset");
    cyc(V_DEF, "post_reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
